ro_freq_counter: RTL and testbench
==================================

RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of the edge counter and of the result.
REQ-002 SHALL have parameter GATE_W, default 16, width of the gate-length input.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, number of clocks between a select change and the start of the gate; legal range 1..255.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: measurement request, sampled only in IDLE.
REQ-007 SHALL have port sel_i, input, 4 bits: index of the ring oscillator to measure (0..15).
REQ-008 SHALL have port gate_len_i, input, GATE_W bits: gate window length, in clocks.
REQ-009 SHALL have port ro_in, input, 1 bit: muxed oscillator output, asynchronous to wb_clk_i.
REQ-010 SHALL have port ro_sel_o, output, 4 bits: drives the 16:1 oscillator mux select.
REQ-011 SHALL have port busy_o, output, 1 bit: high in SETTLE and MEASURE.
REQ-012 SHALL have port done_o, output, 1 bit: single-cycle completion pulse.
REQ-013 SHALL have port count_o, output, CNT_W bits: result of the last completed measurement.
REQ-014 SHALL have port overflow_o, output, 1 bit: the last result saturated.

Function
REQ-015 SHALL synchronise ro_in through two flops, then a third flop; a rising edge is detected in a cycle when flop2=1 and flop3=0.
REQ-016 SHALL implement an FSM with the states IDLE, SETTLE, MEASURE, DONE.
REQ-017 IDLE: when start_i=1 and gate_len_i!=0, SHALL latch sel_i into ro_sel_o, latch gate_len_i, clear the edge counter and its saturation flag, load the settle counter with SETTLE_CYCLES, and go to SETTLE.
REQ-018 IDLE: when start_i=1 and gate_len_i=0, SHALL latch sel_i into ro_sel_o and go directly to DONE with a result of 0 and overflow 0.
REQ-019 SETTLE: SHALL last exactly SETTLE_CYCLES cycles and SHALL NOT count edges; after that it SHALL enter MEASURE.
REQ-020 MEASURE: SHALL last exactly the latched gate length in cycles; the counter SHALL increment by 1 in each MEASURE cycle with a detected edge.
REQ-021 The counter SHALL saturate at 2^CNT_W-1; an edge detected at saturation SHALL set the saturation flag and SHALL leave the count unchanged.
REQ-022 DONE: SHALL last 1 cycle with done_o=1; count_o and overflow_o SHALL update from the counter and the flag on entry to DONE; next state SHALL be IDLE.
REQ-023 Timing: start accepted at cycle 0 gives done_o high at cycle SETTLE_CYCLES+G+1, where G is the latched gate length.
REQ-024 start_i SHALL be ignored outside IDLE; sel_i and gate_len_i changes outside IDLE SHALL have no effect.
REQ-025 count_o, overflow_o and ro_sel_o SHALL hold their values until the next DONE or the next accepted start, respectively.
REQ-026 Measurable frequency: rising edges on ro_in are counted exactly only while the ro_in high and low phases are each at least 2 wb_clk_i periods; faster input is out of range and has an undefined count.

Reset
REQ-027 When wb_rst_i=1, the FSM SHALL go to IDLE and ro_sel_o=0, busy_o=0, done_o=0, count_o=0, overflow_o=0, and all counters and synchroniser flops SHALL be 0.
REQ-028 A reset asserted in SETTLE, MEASURE or DONE SHALL abort the measurement with no done_o pulse; the first start accepted after reset SHALL behave as from power-up.

Verification
REQ-029 SETTLE_CYCLES=4, sel_i=5, gate_len_i=100, ro_in period 10 clocks (50% duty) -> ro_sel_o=5 the cycle after start; busy_o high 104 cycles; done_o at cycle 105; count_o=10 (+/-1 for phase).
REQ-030 ro_in held at 0, then held at 1, gate_len_i=50 -> count_o=0 and overflow_o=0 in both runs.
REQ-031 CNT_W=8, ro_in period 4 clocks, gate_len_i=2000 -> count_o=255 and overflow_o=1; a following run with gate_len_i=40 -> count_o=10 and overflow_o=0.
REQ-032 gate_len_i=0 with start -> done_o at cycle 1, count_o=0, busy_o never high; start_i pulsed mid-MEASURE with sel_i=9 -> ro_sel_o unchanged and exactly one done_o pulse.
REQ-033 wb_rst_i asserted for 1 cycle mid-MEASURE -> the next cycle has busy_o=0, count_o=0, ro_sel_o=0 and no done_o pulse; a restart then completes with the correct count.

Source files
------------

// File: rtl/ro_freq_counter.sv
// ro_freq_counter
//
// Counts rising edges of a selected ring oscillator over a gate window
// measured in wb_clk_i periods. A request in IDLE latches the oscillator
// select and the gate length, waits SETTLE_CYCLES clocks for the mux
// output to settle, counts edges for the gate length, then publishes the
// result with a one-cycle done pulse.
//
// Ports
//   wb_clk_i     clock; all state changes on its rising edge
//   wb_rst_i     synchronous active-high reset
//   start_i      measurement request, looked at only in IDLE
//   sel_i        oscillator index to measure (0..15)
//   gate_len_i   gate window length in clocks (0 = empty measurement)
//   ro_in        muxed oscillator output, asynchronous to wb_clk_i
//   ro_sel_o     oscillator mux select, held until the next accepted start
//   busy_o       high while settling or measuring
//   done_o       one-cycle completion pulse
//   count_o      edge count of the last completed measurement
//   overflow_o   last result saturated at 2^CNT_W-1
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_i; outputs hold the previous result
// SETTLE  | mux select applied, waiting SETTLE_CYCLES clocks, no counting
// MEASURE | gate open, counting synchronised rising edges of ro_in
// DONE    | single cycle, done_o high, result published

module ro_freq_counter #(
   parameter int unsigned CNT_W         = 24,
   parameter int unsigned GATE_W        = 16,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start_i,
   input  logic [3:0]        sel_i,
   input  logic [GATE_W-1:0] gate_len_i,
   input  logic              ro_in,
   output logic [3:0]        ro_sel_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              overflow_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_DONE
   } state_e;

   state_e            state_q,  state_d;
   logic [2:0]        sync_q,   sync_d;
   logic [7:0]        settle_q, settle_d;
   logic [GATE_W-1:0] gate_q,   gate_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              sat_q,    sat_d;
   logic [3:0]        sel_q,    sel_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              ovf_q,    ovf_d;

   logic              edge_det;
   logic              cnt_full;

   // sync_q[1:0] is the metastability pair; sync_q[2] is the delayed copy
   // used only to find the 0->1 transition.
   assign edge_det = sync_q[1] & ~sync_q[2];
   assign cnt_full = (cnt_q == {CNT_W{1'b1}});

   always_comb begin
      state_d  = state_q;
      sync_d   = {sync_q[1:0], ro_in};
      settle_d = settle_q;
      gate_d   = gate_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      sel_d    = sel_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      count_d  = count_q;
      ovf_d    = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sel_d = sel_i;
               if (gate_len_i != '0) begin
                  gate_d   = gate_len_i;
                  cnt_d    = '0;
                  sat_d    = 1'b0;
                  settle_d = 8'(SETTLE_CYCLES);
                  busy_d   = 1'b1;
                  state_d  = ST_SETTLE;
               end else begin
                  // Empty gate: publish a zero result straight away.
                  count_d = '0;
                  ovf_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_SETTLE: begin
            if (settle_q == 8'd1) begin
               state_d = ST_MEASURE;
            end else begin
               settle_d = settle_q - 8'd1;
            end
         end

         ST_MEASURE: begin
            if (edge_det) begin
               if (cnt_full) begin
                  sat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            gate_d = gate_q - GATE_W'(1);
            if (gate_q == GATE_W'(1)) begin
               // Publish the values including an edge seen in this last
               // gate cycle, so the result is ready as DONE is entered.
               count_d = cnt_d;
               ovf_d   = sat_d;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         sync_q   <= '0;
         settle_q <= '0;
         gate_q   <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         settle_q <= settle_d;
         gate_q   <= gate_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ro_sel_o   = sel_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign count_o    = count_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Testbench for ro_freq_counter (CNT_W=8, SETTLE_CYCLES=4).
// The expected count is derived from the recorded ro_in waveform: every
// 0->1 transition of the sampled input whose synchronised detection lands
// inside the gate window, saturated at 255.

module tb_ro_freq_counter;

   localparam int CNT_W  = 8;
   localparam int GATE_W = 16;
   localparam int S      = 4;
   localparam int MAXC   = (1 << CNT_W) - 1;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i = 1'b1;
   logic              start_i = 1'b0;
   logic [3:0]        sel_i = '0;
   logic [GATE_W-1:0] gate_len_i = '0;
   logic              ro_in = 1'b0;
   logic [3:0]        ro_sel_o;
   logic              busy_o;
   logic              done_o;
   logic [CNT_W-1:0]  count_o;
   logic              overflow_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rhist [0:65535];
   int mode = 0;
   int half = 5;
   int ph_left = 0;

   ro_freq_counter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYCLES(S)) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .start_i    (start_i),
      .sel_i      (sel_i),
      .gate_len_i (gate_len_i),
      .ro_in      (ro_in),
      .ro_sel_o   (ro_sel_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .count_o    (count_o),
      .overflow_o (overflow_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Value of ro_in seen by the DUT at rising edge number cyc.
   always @(posedge wb_clk_i) begin
      rhist[cyc] = ro_in;
      cyc = cyc + 1;
   end

   // Oscillator model: 0 = stuck low, 1 = stuck high, 2 = square wave with
   // 'half' clocks per phase, 3 = random phases of 2..7 clocks.
   always begin
      @(posedge wb_clk_i);
      #1;
      case (mode)
         0: ro_in = 1'b0;
         1: ro_in = 1'b1;
         default: begin
            if (ph_left == 0) begin
               ro_in = ~ro_in;
               ph_left = (mode == 2) ? half - 1 : int'($urandom_range(6, 1));
            end else begin
               ph_left = ph_left - 1;
            end
         end
      endcase
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Rising edges at sample indices lo..hi.
   function automatic int edges(input int lo, input int hi);
      int n = 0;
      for (int k = lo; k <= hi; k++)
         if (rhist[k] === 1'b1 && rhist[k-1] === 1'b0) n++;
      return n;
   endfunction

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   // One measurement. poke_at >= 0 pulses start_i with sel_i=9 at that
   // cycle offset while the measurement is running.
   task automatic run(input logic [3:0] sel, input int gate, input int poke_at, input string tag);
      int a, busy_n, done_cyc, n, pulses;
      bit got;
      sel_i = sel;
      gate_len_i = GATE_W'(gate);
      start_i = 1'b1;
      a = cyc;
      tick();
      start_i = 1'b0;
      sel_i = 4'($urandom);
      gate_len_i = GATE_W'($urandom);
      check({tag, "_sel"}, 32'(ro_sel_o), 32'(sel));
      busy_n = 0;
      got = 0;
      done_cyc = 0;
      for (int i = 0; i < S + gate + 20; i++) begin
         if (done_o === 1'b1) begin
            got = 1;
            done_cyc = cyc;
            break;
         end
         if (busy_o === 1'b1) busy_n++;
         if (i == poke_at) begin
            start_i = 1'b1;
            sel_i = 4'd9;
            gate_len_i = GATE_W'(7);
         end
         tick();
         start_i = 1'b0;
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_done_cycle"}, 32'(done_cyc - a), 32'((gate == 0) ? 1 : S + gate + 1));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'((gate == 0) ? 0 : S + gate));
      n = (gate == 0) ? 0 : edges(a + S - 1, a + S + gate - 2);
      check({tag, "_count"}, 32'(count_o), 32'((n > MAXC) ? MAXC : n));
      check({tag, "_ovf"}, 32'(overflow_o), 32'(n > MAXC));
      check({tag, "_sel_hold"}, 32'(ro_sel_o), 32'(sel));
      pulses = 0;
      repeat (6) begin
         tick();
         if (done_o !== 1'b0) pulses++;
      end
      check({tag, "_extra_done"}, 32'(pulses), 32'd0);
   endtask

   initial begin
      int pulses;
      wb_rst_i = 1'b1;
      repeat (3) tick();
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      check("rst_sel", 32'(ro_sel_o), 32'd0);
      wb_rst_i = 1'b0;
      repeat (4) tick();

      // 10-clock square wave, 100-clock gate
      mode = 2; half = 5;
      repeat (12) tick();
      run(4'd5, 100, -1, "sq10");
      check("sq10_range", 32'(count_o >= 9 && count_o <= 11), 32'd1);

      // stuck-at inputs
      mode = 0;
      repeat (8) tick();
      run(4'd2, 50, -1, "stuck0");
      mode = 1;
      repeat (8) tick();
      run(4'd7, 50, -1, "stuck1");

      // saturation, then a clean run clearing the flag
      mode = 2; half = 2;
      repeat (8) tick();
      run(4'd1, 2000, -1, "sat");
      check("sat_cnt_const", 32'(count_o), 32'd255);
      check("sat_ovf_const", 32'(overflow_o), 32'd1);
      run(4'd1, 40, -1, "after_sat");
      check("after_sat_const", 32'(count_o), 32'd10);

      // empty and minimal gates
      run(4'd6, 0, -1, "gate0");
      run(4'd15, 1, -1, "gate1");

      // start pulse while measuring must be ignored
      mode = 3;
      run(4'd4, 80, S + 40, "poke");

      // reset during MEASURE
      sel_i = 4'd3;
      gate_len_i = GATE_W'(200);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (S + 50) tick();
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i = 1'b0;
      check("rstmid_busy", 32'(busy_o), 32'd0);
      check("rstmid_count", 32'(count_o), 32'd0);
      check("rstmid_sel", 32'(ro_sel_o), 32'd0);
      check("rstmid_done", 32'(done_o), 32'd0);
      pulses = 0;
      repeat (220) begin
         tick();
         if (done_o !== 1'b0) pulses++;
      end
      check("rstmid_no_done", 32'(pulses), 32'd0);
      run(4'd11, 120, -1, "restart");

      // randomized runs
      for (int r = 0; r < 10; r++) begin
         mode = 2 + int'($urandom_range(1, 0));
         half = int'($urandom_range(6, 2));
         repeat (int'($urandom_range(10, 3))) tick();
         run(4'($urandom), int'($urandom_range(300, 1)), -1, $sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
